// File: rtl/ammo_resupply_ctrl_pkg.sv
// Shared definitions for the ammo resupply path: FSM encoding, default sizing, mode codes.
// Included by the resupply controller and later by the weapons saturation counter.
package ammo_resupply_ctrl_pkg;

  localparam int unsigned AMMO_W_DEF   = 9;
  localparam int unsigned MAX_AMMO_DEF = 500;
  localparam int unsigned BEAT_W_DEF   = 5;
  localparam int unsigned COOLDOWN_DEF = 4;

  localparam logic [3:0] ATTACK_MODE_CODE = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_FILL   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_COOL   = 3'd4
  } state_t;

  // A zero cooldown still needs a legal one-bit counter.
  function automatic int unsigned cool_cnt_width(input int unsigned cooldown);
    return (cooldown < 1) ? 1 : $clog2(cooldown + 1);
  endfunction

endpackage

// File: rtl/resupply_sat_add.sv
// Saturating adder: base count plus one supply beat, clamped to the magazine ceiling.
// Purely combinational; shared with the weapons counter.
module resupply_sat_add #(
  parameter int unsigned N        = 9,
  parameter int unsigned BEAT_W   = 5,
  parameter int unsigned MAX_AMMO = 500
) (
  input  logic [N-1:0]      i_base,
  input  logic [BEAT_W-1:0] i_add,
  output logic [N-1:0]      o_sum
);

  localparam logic [N:0] MAX_W = (N+1)'(MAX_AMMO);

  logic [N:0] w_sum;

  // One extra bit so a beat on a nearly full magazine cannot wrap before the clamp.
  assign w_sum = {1'b0, i_base} + {{(N+1-BEAT_W){1'b0}}, i_add};
  assign o_sum = (w_sum >= MAX_W) ? MAX_W[N-1:0] : w_sum[N-1:0];

endmodule

// File: rtl/ammo_resupply_ctrl.sv
// Reload controller: snapshots the magazine, accepts depot beats (ready only in FILL), commits one load strobe.
// Commit lands one cycle after the last beat; define RESUPPLY_INTERLOCK_EN to add the fire_inhibit output.
module ammo_resupply_ctrl
  import ammo_resupply_ctrl_pkg::*;
#(
  parameter int unsigned N        = AMMO_W_DEF,
  parameter int unsigned MAX_AMMO = MAX_AMMO_DEF,
  parameter int unsigned BEAT_W   = BEAT_W_DEF,
  parameter int unsigned COOLDOWN = COOLDOWN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_req,
  input  logic [N-1:0]      ammo_cur,
  input  logic              sup_valid,
  input  logic [BEAT_W-1:0] sup_rounds,
  output logic              sup_ready,
  output logic              ammo_load,
  output logic [N-1:0]      ammo_val,
  output logic              reloading
`ifdef RESUPPLY_INTERLOCK_EN
  ,
  output logic              fire_inhibit
`endif
);

  localparam int unsigned      CNT_W     = cool_cnt_width(COOLDOWN);
  localparam logic [N-1:0]     MAX_N     = N'(MAX_AMMO);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);

  state_t           r_state;
  logic [N-1:0]     r_acc;
  logic [CNT_W-1:0] r_cool_cnt;

  state_t           w_state_nxt;
  logic [N-1:0]     w_acc_nxt;
  logic [CNT_W-1:0] w_cool_nxt;
  logic [N-1:0]     w_sum;
  logic             w_beat;

  resupply_sat_add #(
    .N        (N),
    .BEAT_W   (BEAT_W),
    .MAX_AMMO (MAX_AMMO)
  ) u_sat_add (
    .i_base (r_acc),
    .i_add  (sup_rounds),
    .o_sum  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_cool_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cool_cnt <= w_cool_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cool_nxt  = r_cool_cnt;
    sup_ready   = 1'b0;
    ammo_load   = 1'b0;
    ammo_val    = '0;
    reloading   = 1'b0;
    w_beat      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (reload_req) w_state_nxt = ST_SNAP;
      end
      ST_SNAP: begin
        reloading = 1'b1;
        w_acc_nxt = ammo_cur;
        w_state_nxt = (ammo_cur >= MAX_N) ? ST_IDLE : ST_FILL;
      end
      ST_FILL: begin
        reloading = 1'b1;
        sup_ready = 1'b1;
        w_beat    = sup_valid;
        if (w_beat) w_acc_nxt = w_sum;
        // An abort in the same cycle as a beat still keeps that beat.
        if ((w_beat && (w_sum == MAX_N)) || !reload_req) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        reloading   = 1'b1;
        ammo_load   = 1'b1;
        ammo_val    = r_acc;
        w_cool_nxt  = '0;
        w_state_nxt = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
      end
      ST_COOL: begin
        if (r_cool_cnt == COOL_LAST) begin
          w_cool_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cool_nxt = r_cool_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef RESUPPLY_INTERLOCK_EN
  logic r_fire_inhibit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fire_inhibit <= 1'b0;
    end else begin
      r_fire_inhibit <= (w_state_nxt == ST_SNAP) || (w_state_nxt == ST_FILL) ||
                        (w_state_nxt == ST_COMMIT);
    end
  end

  assign fire_inhibit = r_fire_inhibit;
`endif

endmodule
